// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 host transmitter and the PS/2
// receive path.
//   - tx_state_t     : host transmit FSM state encoding
//   - REG_DATA/STATUS: Wishbone register byte offsets
//   - STAT_*         : bit positions inside the STATUS register
//   - CMD_*          : common keyboard command bytes
//   - odd_parity()   : PS/2 frame parity (odd over the eight data bits)
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_BITS,
        ST_ACK,
        ST_WAITIDLE
    } tx_state_t;

    localparam logic [31:0] REG_DATA   = 32'h0;
    localparam logic [31:0] REG_STATUS = 32'h4;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_NACK = 2;
    localparam int STAT_TMO  = 3;
    localparam int STAT_OVR  = 4;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    // The parity bit makes the total count of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: Wishbone slave bus used by the PS/2 host transmitter.
//   dat_i  [31:0]  write data (master -> slave)
//   adr_i  [31:0]  address, only bit 2 is decoded (master -> slave)
//   we_i           write enable (master -> slave)
//   stb_i          strobe (master -> slave)
//   dat_o  [31:0]  read data, valid with ack_o (slave -> master)
//   ack_o          single-cycle acknowledge (slave -> master)
interface ps2_host_tx_if;

    logic [31:0] dat_i;
    logic [31:0] adr_i;
    logic        we_i;
    logic        stb_i;
    logic [31:0] dat_o;
    logic        ack_o;

    modport master (
        output dat_i, adr_i, we_i, stb_i,
        input  dat_o, ack_o
    );

    modport slave (
        input  dat_i, adr_i, we_i, stb_i,
        output dat_o, ack_o
    );

endinterface

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: conditions one asynchronous open-drain PS/2 pad input.
// A 2-flop synchronizer feeds a glitch filter that only accepts a new level
// after FILTER_LEN consecutive samples disagree with the current one.
//   clk, rst  system clock, synchronous active-high reset
//   pad_i     raw pad input (asynchronous)
//   level_o   filtered line level (resets to 1, the idle pulled-up level)
//   fall_o    one-cycle pulse when level_o goes 1 -> 0
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pad_i,
    output logic level_o,
    output logic fall_o
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    // Two-stage synchronizer; resets to the idle-high line level so that
    // leaving reset never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= pad_i;
            sync_2 <= sync_1;
        end
    end

    // Any sample agreeing with the accepted level restarts the run count,
    // so a shorter pulse never gets through. The edge pulse is raised in
    // the same cycle the new level is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_o <= 1'b1;
            fall_o  <= 1'b0;
            cnt     <= '0;
        end else begin
            fall_o <= 1'b0;
            if (sync_2 == level_o) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level_o <= sync_2;
                fall_o  <= level_o;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter with a Wishbone register
// window (DATA at 0x0, STATUS at 0x4) and a level completion interrupt.
//   clk, rst                 system clock, synchronous active-high reset
//   bus                      Wishbone slave (ps2_host_tx_if.slave)
//   ps2_clk_i, ps2_data_i    asynchronous pad inputs
//   ps2_clk_oe, ps2_data_oe  1 = pull the pad low, 0 = release it
//   tx_irq                   level interrupt, set on DONE/NACK/TMO
//   tx_iack                  interrupt acknowledge
//   tx_busy                  high while a transmission owns the lines
// Build option: define PS2_TX_TIMEOUT_EN to add a watchdog that abandons a
// frame after TIMEOUT_CYCLES once the clock line has been handed to the
// device.
import ps2_pkg::*;

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic                clk,
    input  logic                rst,
    ps2_host_tx_if.slave        bus,
    input  logic                ps2_clk_i,
    input  logic                ps2_data_i,
    output logic                ps2_clk_oe,
    output logic                ps2_data_oe,
    output logic                tx_irq,
    input  logic                tx_iack,
    output logic                tx_busy
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

    tx_state_t        state;
    tx_state_t        state_nxt;
    logic [7:0]       tx_byte;
    logic [9:0]       frame;
    logic [3:0]       bit_cnt;
    logic             cur_bit;
    logic [INH_W-1:0] inh_cnt;
    logic             st_done;
    logic             st_nack;
    logic             st_tmo;
    logic             st_ovr;
    logic             clk_level;
    logic             clk_fall;
    logic             data_level;
    logic             data_fall_unused;
    logic             bus_take;
    logic             wr_data;
    logic             wr_status;
    logic             start;
    logic             timeout;
    logic             clk_oe_d;
    logic             data_oe_d;
    logic             done_evt;
    logic             nack_evt;
    logic             unused_bits;

    assign unused_bits = ^{bus.adr_i[31:3], bus.adr_i[1:0], bus.dat_i[31:8]};

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk     (clk),
        .rst     (rst),
        .pad_i   (ps2_clk_i),
        .level_o (clk_level),
        .fall_o  (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk     (clk),
        .rst     (rst),
        .pad_i   (ps2_data_i),
        .level_o (data_level),
        .fall_o  (data_fall_unused)
    );

    // A new access is taken only when no ack is outstanding, which spaces
    // acks of a held strobe two cycles apart.
    assign bus_take  = bus.stb_i & ~bus.ack_o;
    assign wr_data   = bus_take & bus.we_i & ~bus.adr_i[2];
    assign wr_status = bus_take & bus.we_i &  bus.adr_i[2];
    assign start     = wr_data & (state == ST_IDLE);
    assign tx_busy   = (state != ST_IDLE);

`ifdef PS2_TX_TIMEOUT_EN
    logic [20:0] wd_cnt;

    // The watchdog only runs once the device owns the clock; the inhibit
    // period is under host control and cannot stall.
    always_ff @(posedge clk) begin
        if (rst || state == ST_IDLE || state == ST_INHIBIT) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign timeout = (state != ST_IDLE) && (state != ST_INHIBIT) &&
                     (wd_cnt == 21'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // State register of the transmit FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and line-drive decode. A timeout overrides everything and
    // drops back to IDLE with both lines released.
    always_comb begin
        state_nxt = state;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        done_evt  = 1'b0;
        nack_evt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_INHIBIT;
            end
            ST_INHIBIT: begin
                clk_oe_d = 1'b1;
                if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                    data_oe_d = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                data_oe_d = 1'b1;
                if (clk_fall) state_nxt = ST_BITS;
            end
            ST_BITS: begin
                data_oe_d = ~cur_bit;
                if (clk_fall && bit_cnt == 4'd9) state_nxt = ST_ACK;
            end
            ST_ACK: begin
                if (clk_fall) begin
                    nack_evt  = data_level;
                    state_nxt = ST_WAITIDLE;
                end
            end
            ST_WAITIDLE: begin
                if (clk_level && data_level) begin
                    done_evt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (timeout) begin
            state_nxt = ST_IDLE;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_evt  = 1'b0;
            nack_evt  = 1'b0;
        end
    end

    // Line drivers are registered so the pads never see decode glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            ps2_clk_oe  <= clk_oe_d;
            ps2_data_oe <= data_oe_d;
        end
    end

    // Frame datapath. The frame is stop/parity/data so bit_cnt indexes it
    // directly; cur_bit starts at 0, which is the start bit held in REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_byte <= '0;
            frame   <= '0;
            bit_cnt <= '0;
            cur_bit <= 1'b0;
            inh_cnt <= '0;
        end else begin
            if (start) begin
                tx_byte <= bus.dat_i[7:0];
                frame   <= {1'b1, odd_parity(bus.dat_i[7:0]), bus.dat_i[7:0]};
                bit_cnt <= '0;
                cur_bit <= 1'b0;
            end
            if (state == ST_INHIBIT) begin
                inh_cnt <= inh_cnt + 1'b1;
            end else begin
                inh_cnt <= '0;
            end
            if (state == ST_BITS && clk_fall) begin
                cur_bit <= frame[bit_cnt];
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    // Sticky status and interrupt. Events are applied after the clears so
    // that a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_done <= 1'b0;
            st_nack <= 1'b0;
            st_tmo  <= 1'b0;
            st_ovr  <= 1'b0;
            tx_irq  <= 1'b0;
        end else begin
            if (start) begin
                st_done <= 1'b0;
                st_nack <= 1'b0;
                st_tmo  <= 1'b0;
            end
            if (wr_data && state != ST_IDLE) st_ovr <= 1'b1;
            if (wr_status) begin
                if (bus.dat_i[STAT_DONE]) st_done <= 1'b0;
                if (bus.dat_i[STAT_NACK]) st_nack <= 1'b0;
                if (bus.dat_i[STAT_TMO])  st_tmo  <= 1'b0;
                if (bus.dat_i[STAT_OVR])  st_ovr  <= 1'b0;
            end
            if (done_evt) st_done <= 1'b1;
            if (nack_evt) st_nack <= 1'b1;
            if (timeout)  st_tmo  <= 1'b1;
            if (done_evt || nack_evt || timeout) begin
                tx_irq <= 1'b1;
            end else if (tx_iack || (wr_status && bus.dat_i[STAT_DONE])) begin
                tx_irq <= 1'b0;
            end
        end
    end

    // Wishbone response: ack one cycle after the strobe is taken, with read
    // data presented only alongside that ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ack_o <= 1'b0;
            bus.dat_o <= '0;
        end else begin
            bus.ack_o <= bus_take;
            bus.dat_o <= '0;
            if (bus_take && !bus.we_i) begin
                if (bus.adr_i[2]) begin
                    bus.dat_o <= {27'd0, st_ovr, st_tmo, st_nack, st_done, tx_busy};
                end else begin
                    bus.dat_o <= {24'd0, tx_byte};
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives the transmitter over Wishbone and plays the PS/2
// keyboard side with a behavioural device that clocks frames in at a
// 20-cycle half period. Commands written to DATA are queued as expected
// frames; the device checks every received frame against that queue.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int HALF = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_host_tx_if bus();

    logic ps2_clk_oe;
    logic ps2_data_oe;
    logic tx_irq;
    logic tx_iack;
    logic tx_busy;

    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    logic glitch   = 1'b0;

    // Open-drain pads: whoever pulls low wins.
    wire ps2_clk_i  = ~ps2_clk_oe & dev_clk & ~glitch;
    wire ps2_data_i = ~ps2_data_oe & dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES (50),
        .FILTER_LEN     (2),
        .TIMEOUT_CYCLES (2000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_irq      (tx_irq),
        .tx_iack     (tx_iack),
        .tx_busy     (tx_busy)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];
    bit dev_nack   = 0;
    bit dev_mute   = 0;
    bit dev_glitch = 0;
    bit dev_abort  = 0;
    int dev_falls  = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] adr, input logic [31:0] wdat,
                                 input logic we, output logic [31:0] rdat);
        @(negedge clk);
        bus.adr_i = adr;
        bus.dat_i = wdat;
        bus.we_i  = we;
        bus.stb_i = 1'b1;
        @(negedge clk);
        checkOutput("wb_ack", {31'd0, bus.ack_o}, 32'd1);
        rdat      = bus.dat_o;
        bus.stb_i = 1'b0;
        bus.we_i  = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (tx_busy === 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {31'd0, tx_busy}, 32'd0);
    endtask

    // Behavioural keyboard: measures the inhibit pulse, clocks in start,
    // eight data bits, parity and stop (sampled just before each rising
    // edge), then answers in the ack slot and scores the frame.
    initial begin : device
        logic [10:0] rx;
        logic [7:0]  exp_b;
        logic        exp_par;
        int          inh_len;
        bit          aborted;
        forever begin
            do @(negedge clk); while (ps2_clk_oe !== 1'b1);
            inh_len = 0;
            while (ps2_clk_oe === 1'b1) begin
                inh_len++;
                @(negedge clk);
            end
            checkOutput("inhibit_len", inh_len, 50);
            checkOutput("rts_data_low", {31'd0, ps2_data_oe}, 32'd1);
            if (dev_mute) continue;
            repeat (30) @(negedge clk);
            aborted = 0;
            rx = '0;
            for (int i = 0; i < 11; i++) begin
                if (dev_abort && i == 5) begin
                    aborted = 1;
                    break;
                end
                dev_clk = 1'b0;
                dev_falls++;
                repeat (HALF) @(negedge clk);
                rx[i]   = ps2_data_i;
                dev_clk = 1'b1;
                if (dev_glitch && i == 4) begin
                    repeat (10) @(negedge clk);
                    glitch = 1'b1;
                    @(negedge clk);
                    glitch = 1'b0;
                    repeat (HALF - 11) @(negedge clk);
                end else begin
                    repeat (HALF) @(negedge clk);
                end
            end
            if (!aborted) begin
                if (!dev_nack) dev_data = 1'b0;
                repeat (10) @(negedge clk);
                dev_clk = 1'b0;
                dev_falls++;
                repeat (HALF) @(negedge clk);
                dev_clk = 1'b1;
                repeat (5) @(negedge clk);
                dev_data = 1'b1;
                if (exp_q.size() == 0) begin
                    checkOutput("frame_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_b   = exp_q.pop_front();
                    exp_par = ($countones(exp_b) % 2 == 0);
                    checkOutput("start_bit",  {31'd0, rx[0]}, 32'd0);
                    checkOutput("data_byte",  {24'd0, rx[8:1]}, {24'd0, exp_b});
                    checkOutput("parity_bit", {31'd0, rx[9]}, {31'd0, exp_par});
                    checkOutput("stop_bit",   {31'd0, rx[10]}, 32'd1);
                end
            end
        end
    end

    initial begin : main
        logic [31:0] r;
        int n;
        bus.stb_i = 1'b0;
        bus.we_i  = 1'b0;
        bus.adr_i = '0;
        bus.dat_i = '0;
        tx_iack   = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_clk_oe",  {31'd0, ps2_clk_oe},  32'd0);
        checkOutput("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        checkOutput("rst_irq",     {31'd0, tx_irq},      32'd0);
        checkOutput("rst_busy",    {31'd0, tx_busy},     32'd0);
        checkOutput("rst_ack",     {31'd0, bus.ack_o},   32'd0);
        rst = 1'b0;
        applyStimulus(REG_STATUS, 32'd0, 1'b0, r);
        checkOutput("rst_status", r, 32'd0);

        // 0xED with ACK
        dev_nack = 0;
        exp_q.push_back(CMD_SET_LEDS);
        applyStimulus(REG_DATA, {24'd0, CMD_SET_LEDS}, 1'b1, r);
        @(negedge clk);
        checkOutput("clk_oe_after_write", {31'd0, ps2_clk_oe}, 32'd1);
        waitIdle("t1_complete");
        @(negedge clk);
        checkOutput("t1_irq", {31'd0, tx_irq}, 32'd1);
        applyStimulus(REG_STATUS, 32'd0, 1'b0, r);
        checkOutput("t1_status", r, 32'd1 << STAT_DONE);
        applyStimulus(REG_DATA, 32'd0, 1'b0, r);
        checkOutput("t1_data_readback", r, {24'd0, CMD_SET_LEDS});
        @(negedge clk);
        tx_iack = 1'b1;
        @(negedge clk);
        tx_iack = 1'b0;
        checkOutput("t1_iack_clears_irq", {31'd0, tx_irq}, 32'd0);
        applyStimulus(REG_STATUS, 32'd1 << STAT_DONE, 1'b1, r);

        // 0x00 with NACK
        dev_nack = 1;
        exp_q.push_back(8'h00);
        applyStimulus(REG_DATA, 32'h0, 1'b1, r);
        waitIdle("t2_complete");
        @(negedge clk);
        checkOutput("t2_irq", {31'd0, tx_irq}, 32'd1);
        applyStimulus(REG_STATUS, 32'd0, 1'b0, r);
        checkOutput("t2_status", r, (32'd1 << STAT_DONE) | (32'd1 << STAT_NACK));
        applyStimulus(REG_STATUS, 32'h6, 1'b1, r);
        @(negedge clk);
        checkOutput("t2_w1c_clears_irq", {31'd0, tx_irq}, 32'd0);
        dev_nack = 0;

        // Write while busy is dropped and flags OVR
        exp_q.push_back(CMD_ENABLE);
        applyStimulus(REG_DATA, {24'd0, CMD_ENABLE}, 1'b1, r);
        repeat (10) @(negedge clk);
        applyStimulus(REG_DATA, {24'd0, CMD_RESET}, 1'b1, r);
        waitIdle("t3_complete");
        applyStimulus(REG_STATUS, 32'd0, 1'b0, r);
        checkOutput("t3_status", r, (32'd1 << STAT_DONE) | (32'd1 << STAT_OVR));
        applyStimulus(REG_DATA, 32'd0, 1'b0, r);
        checkOutput("t3_data_readback", r, {24'd0, CMD_ENABLE});
        applyStimulus(REG_STATUS, 32'h12, 1'b1, r);
        applyStimulus(REG_STATUS, 32'd0, 1'b0, r);
        checkOutput("t3_status_cleared", r, 32'd0);

        // Glitch on the clock line with random payload after
        dev_glitch = 1;
        exp_q.push_back(CMD_SET_LEDS);
        applyStimulus(REG_DATA, {24'd0, CMD_SET_LEDS}, 1'b1, r);
        waitIdle("t6_complete");
        dev_glitch = 0;
        applyStimulus(REG_STATUS, 32'd0, 1'b0, r);
        checkOutput("t6_status", r, 32'd1 << STAT_DONE);
        for (int k = 0; k < 3; k++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            dev_nack = 0;
            exp_q.push_back(b);
            applyStimulus(REG_DATA, {24'd0, b}, 1'b1, r);
            waitIdle("rand_complete");
            applyStimulus(REG_DATA, 32'd0, 1'b0, r);
            checkOutput("rand_data_readback", r, {24'd0, b});
        end
        // tx_irq stays set from the last frame so the reset has something to clear

        // Reset in the middle of a frame
        dev_abort = 1;
        dev_falls = 0;
        applyStimulus(REG_DATA, {24'd0, CMD_SET_LEDS}, 1'b1, r);
        n = 0;
        while (dev_falls < 5 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t5_reached_bit5", {31'd0, (dev_falls >= 5)}, 32'd1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t5_clk_oe",  {31'd0, ps2_clk_oe},  32'd0);
        checkOutput("t5_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        checkOutput("t5_busy",    {31'd0, tx_busy},     32'd0);
        checkOutput("t5_irq",     {31'd0, tx_irq},      32'd0);
        rst = 1'b0;
        applyStimulus(REG_STATUS, 32'd0, 1'b0, r);
        checkOutput("t5_status", r, 32'd0);
        repeat (60) @(negedge clk);
        dev_abort = 0;

`ifdef PS2_TX_TIMEOUT_EN
        // Dead device: watchdog must abandon the frame
        dev_mute = 1;
        applyStimulus(REG_DATA, {24'd0, CMD_SET_LEDS}, 1'b1, r);
        n = 0;
        while (ps2_clk_oe !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        while (ps2_clk_oe === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (tx_busy === 1'b1 && n < 2500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t4_tmo_window", {31'd0, (n >= 1990 && n <= 2010)}, 32'd1);
        repeat (2) @(negedge clk);
        checkOutput("t4_clk_oe",  {31'd0, ps2_clk_oe},  32'd0);
        checkOutput("t4_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        checkOutput("t4_irq",     {31'd0, tx_irq},      32'd1);
        applyStimulus(REG_STATUS, 32'd0, 1'b0, r);
        checkOutput("t4_status", r, 32'd1 << STAT_TMO);
        dev_mute = 0;
`endif

        checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin : global_guard
        #1000000;
        $display("[TB] FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "[TB] stopped");
    end

endmodule
